// File: rtl/jk_pkg.sv
// Shared types for the JK bank driver: FSM state encoding and per-bit J/K excitation codes.
package jk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    typedef struct packed {
        logic j;
        logic k;
    } jk_exc_t;

    localparam jk_exc_t EXC_HOLD   = jk_exc_t'(2'b00);
    localparam jk_exc_t EXC_RESET  = jk_exc_t'(2'b01);
    localparam jk_exc_t EXC_SET    = jk_exc_t'(2'b10);
    localparam jk_exc_t EXC_TOGGLE = jk_exc_t'(2'b11);

    // Excitation needed to move one flip-flop from q to t on the next edge.
    function automatic jk_exc_t jk_excite_bit(input logic q, input logic t, input logic toggle);
        jk_exc_t exc;
        exc = EXC_HOLD;
        if (q != t) begin
            if (toggle) begin
                exc = EXC_TOGGLE;
            end else if (t) begin
                exc = EXC_SET;
            end else begin
                exc = EXC_RESET;
            end
        end
        return exc;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational N-wide J/K excitation from current bank value q toward target t.
module jk_excite
    import jk_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter bit          TOGGLE_MODE = 1'b0
) (
    input  logic [N-1:0] i_q,
    input  logic [N-1:0] i_t,
    output logic [N-1:0] o_j,
    output logic [N-1:0] o_k
);

    jk_exc_t w_exc [N];

    for (genvar gi = 0; gi < int'(N); gi++) begin : g_bit
        assign w_exc[gi] = jk_excite_bit(i_q[gi], i_t[gi], TOGGLE_MODE);
        assign o_j[gi]   = w_exc[gi].j;
        assign o_k[gi]   = w_exc[gi].k;
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives one J/K excitation cycle into a JK flip-flop bank per accepted target,
// then checks the bank landed on the target with complementary outputs.
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter bit          TOGGLE_MODE = 1'b0
) (
    input  logic         CLK,
    input  logic         rst_n,
    input  logic         iValid,
    output logic         oReady,
    input  logic [N-1:0] iTarget,
    input  logic [N-1:0] iQ,
    input  logic [N-1:0] iQn,
    output logic [N-1:0] oJ,
    output logic [N-1:0] oK,
    output logic         oDone,
    output logic         oErr
);

    state_t       r_state;
    logic [N-1:0] r_target;
    logic [N-1:0] r_j;
    logic [N-1:0] r_k;
    logic         r_ready;
    logic         r_done;
    logic         r_err;

    logic [N-1:0] w_j;
    logic [N-1:0] w_k;
    logic         w_accept;
    logic         w_mismatch;

    jk_excite #(
        .N           (N),
        .TOGGLE_MODE (TOGGLE_MODE)
    ) u_excite (
        .i_q (iQ),
        .i_t (iTarget),
        .o_j (w_j),
        .o_k (w_k)
    );

    assign w_accept   = iValid && r_ready;
    // Either a wrong bank value or a pair of outputs that are not complementary.
    assign w_mismatch = (|(iQ ^ r_target)) || !(&(iQ ^ iQn));

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_target <= iTarget;
                        r_j      <= w_j;
                        r_k      <= w_k;
                        r_ready  <= 1'b0;
                        r_state  <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    r_j     <= '0;
                    r_k     <= '0;
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    r_done  <= 1'b1;
                    r_err   <= w_mismatch;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_j     <= '0;
                    r_k     <= '0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oReady = r_ready;
    assign oJ     = r_j;
    assign oK     = r_k;
    assign oDone  = r_done;
    assign oErr   = r_err;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench: two drivers (set/reset and toggle excitation) each closing the loop through a JK bank model.
module tb_jk_bank_driver;

    localparam int unsigned N = 4;

    typedef struct {
        logic [N-1:0] target;
        logic [N-1:0] j0;
        logic [N-1:0] k0;
        logic [N-1:0] j1;
        logic [N-1:0] k1;
        logic [N-1:0] q;
        logic [N-1:0] stuck;
        logic [N-1:0] qnflip;
        logic         err;
        logic         pulse;
    } vec_t;

    logic         CLK;
    logic         rst_n;
    logic         iValid;
    logic [N-1:0] iTarget;
    logic [N-1:0] stuck;
    logic [N-1:0] qnflip;

    logic [N-1:0] q0, q1;
    logic [N-1:0] iq0, iqn0, iq1, iqn1;
    logic [N-1:0] j0, k0, j1, k1;
    logic         ready0, ready1, done0, done1, err0, err1;

    int n_checks;
    int n_fail;
    vec_t vecs [10];

    jk_bank_driver #(.N(N), .TOGGLE_MODE(1'b0)) u_drv0 (
        .CLK(CLK), .rst_n(rst_n), .iValid(iValid), .oReady(ready0),
        .iTarget(iTarget), .iQ(iq0), .iQn(iqn0),
        .oJ(j0), .oK(k0), .oDone(done0), .oErr(err0)
    );

    jk_bank_driver #(.N(N), .TOGGLE_MODE(1'b1)) u_drv1 (
        .CLK(CLK), .rst_n(rst_n), .iValid(iValid), .oReady(ready1),
        .iTarget(iTarget), .iQ(iq1), .iQn(iqn1),
        .oJ(j1), .oK(k1), .oDone(done1), .oErr(err1)
    );

    // JK bank model: Q+ = J&~Q | ~K&Q, async clear to Q=0.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            q0 <= '0;
            q1 <= '0;
        end else begin
            q0 <= (j0 & ~q0) | (~k0 & q0);
            q1 <= (j1 & ~q1) | (~k1 & q1);
        end
    end

    // Fault injection on the feedback path.
    assign iq0  = q0 & ~stuck;
    assign iqn0 = ~q0 ^ qnflip;
    assign iq1  = q1 & ~stuck;
    assign iqn1 = ~q1 ^ qnflip;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic run_vec(input int idx);
        vec_t v;
        int   guard;
        v = vecs[idx];
        guard = 0;
        while (ready0 !== 1'b1 && guard < 10) begin
            @(posedge CLK); #1;
            guard++;
        end
        chk($sformatf("v%0d ready_before", idx), 32'(ready0), 32'd1);
        stuck   = v.stuck;
        qnflip  = v.qnflip;
        iTarget = v.target;
        iValid  = 1'b1;
        @(posedge CLK); #1;
        iValid = 1'b0;
        chk($sformatf("v%0d drive_ready0", idx), 32'(ready0), 32'd0);
        chk($sformatf("v%0d drive_done0", idx), 32'(done0), 32'd0);
        chk($sformatf("v%0d drive_j0", idx), 32'(j0), 32'(v.j0));
        chk($sformatf("v%0d drive_k0", idx), 32'(k0), 32'(v.k0));
        chk($sformatf("v%0d drive_j1", idx), 32'(j1), 32'(v.j1));
        chk($sformatf("v%0d drive_k1", idx), 32'(k1), 32'(v.k1));
        if (v.pulse) begin
            iValid  = 1'b1;
            iTarget = ~v.target;
        end
        @(posedge CLK); #1;
        chk($sformatf("v%0d check_ready0", idx), 32'(ready0), 32'd0);
        chk($sformatf("v%0d check_done0", idx), 32'(done0), 32'd0);
        chk($sformatf("v%0d check_jk0", idx), 32'({j0, k0}), 32'd0);
        chk($sformatf("v%0d check_jk1", idx), 32'({j1, k1}), 32'd0);
        chk($sformatf("v%0d bank_q0", idx), 32'(q0), 32'(v.q));
        chk($sformatf("v%0d bank_q1", idx), 32'(q1), 32'(v.q));
        @(posedge CLK); #1;
        iValid = 1'b0;
        chk($sformatf("v%0d done0", idx), 32'(done0), 32'd1);
        chk($sformatf("v%0d done1", idx), 32'(done1), 32'd1);
        chk($sformatf("v%0d err0", idx), 32'(err0), 32'(v.err));
        chk($sformatf("v%0d err1", idx), 32'(err1), 32'(v.err));
        chk($sformatf("v%0d done_ready0", idx), 32'(ready0), 32'd1);
        chk($sformatf("v%0d done_ready1", idx), 32'(ready1), 32'd1);
        stuck  = '0;
        qnflip = '0;
    endtask

    initial begin
        bit seen_done;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        iValid   = 1'b0;
        iTarget  = '0;
        stuck    = '0;
        qnflip   = '0;

        //              target   j0       k0       j1       k1       q        stuck    qnflip   err   pulse
        vecs[0] = '{4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[1] = '{4'b0110, 4'b0100, 4'b1000, 4'b1100, 4'b1100, 4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vecs[2] = '{4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vecs[3] = '{4'b0000, 4'b0000, 4'b0110, 4'b0110, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0};
        vecs[5] = '{4'b1001, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b1001, 4'b0000, 4'b1000, 1'b1, 1'b0};
        vecs[6] = '{4'b1111, 4'b0110, 4'b0000, 4'b0110, 4'b0110, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[7] = '{4'b0101, 4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[8] = '{4'b0011, 4'b0011, 4'b0000, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[9] = '{4'b1100, 4'b1100, 4'b0011, 4'b1111, 4'b1111, 4'b1100, 4'b0000, 4'b0000, 1'b0, 1'b0};

        // Power-on reset.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_ready0", 32'(ready0), 32'd1);
        chk("rst_jk0", 32'({j0, k0}), 32'd0);
        chk("rst_done_err0", 32'({done0, err0}), 32'd0);
        chk("rst_ready1", 32'(ready1), 32'd1);
        @(posedge CLK); @(posedge CLK); #1;
        rst_n = 1'b1;
        chk("rst_q0", 32'(q0), 32'd0);
        chk("rst_qn0", 32'(iqn0), 32'hF);
        @(posedge CLK); #1;

        for (int i = 0; i < 8; i++) begin
            run_vec(i);
        end
        @(posedge CLK); #1;
        chk("done_single_cycle", 32'(done0), 32'd0);

        // Abort a request in DRIVE with reset; bank currently 0101.
        iTarget = 4'b1100;
        iValid  = 1'b1;
        @(posedge CLK); #1;
        iValid = 1'b0;
        chk("abort_drive_j0", 32'(j0), 32'b1000);
        chk("abort_drive_k0", 32'(k0), 32'b0001);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_jk0", 32'({j0, k0}), 32'd0);
        chk("abort_jk1", 32'({j1, k1}), 32'd0);
        chk("abort_ready0", 32'(ready0), 32'd1);
        chk("abort_done0", 32'(done0), 32'd0);
        chk("abort_q0", 32'(q0), 32'd0);
        @(posedge CLK); #1;
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            if (done0 === 1'b1 || done1 === 1'b1) seen_done = 1'b1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        chk("abort_ready_after", 32'(ready0), 32'd1);
        chk("abort_qn0", 32'(iqn0), 32'hF);

        // Back-to-back: second request accepted in the first one's done cycle.
        run_vec(8);
        run_vec(9);
        @(posedge CLK); #1;
        chk("b2b_done_low", 32'(done0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_bank_driver.md
# jk_bank_driver

Sequencing controller that drives an N-bit bank of JK flip-flops (each with `oQ1`/`oQ2` true/complement outputs, async active-low reset to Q=0/Qn=1) from a requested target value. It accepts a target over a valid/ready handshake and computes per-bit J/K excitation from the bank's fed-back Q. It drives that excitation for exactly one clock, then checks that the bank landed on the target with complementary outputs. It sits between a test/stimulus source and the flip-flop bank, sharing the bank's clock and reset.

## Interface
Parameters:
- `N`, 4, bank width in bits (≥1)
- `TOGGLE_MODE`, 0, 0: changing bits use set/reset excitation; 1: changing bits use J=K=1 (toggle)

Ports:
- `CLK`  input  1  single clock, rising edge
- `rst_n`  input  1  reset, asynchronous, active-low
- `iValid`  input  1  target request valid
- `oReady`  output  1  driver idle, can accept a request
- `iTarget`  input  N  requested next bank value
- `iQ`  input  N  bank true outputs (`oQ1` of each FF)
- `iQn`  input  N  bank complement outputs (`oQ2` of each FF)
- `oJ`  output  N  J excitation to bank, registered
- `oK`  output  N  K excitation to bank, registered
- `oDone`  output  1  one-cycle completion pulse, registered
- `oErr`  output  1  check result, valid only while `oDone`=1, registered

## Operation
- FSM states: IDLE, DRIVE, CHECK.
- IDLE: `oReady`=1, `oJ`=`oK`=0 (bank holds). On `iValid && oReady` at an edge: latch `iTarget`, compute excitation from the current `iQ`, load `oJ`/`oK`, go to DRIVE.
- Per-bit excitation, q→t:
  - 0→0: J=0, K=0
  - 1→1: J=0, K=0
  - 0→1: J=1, K=0 (TOGGLE_MODE=1: J=1, K=1)
  - 1→0: J=0, K=1 (TOGGLE_MODE=1: J=1, K=1)
- DRIVE: `oReady`=0. `oJ`/`oK` hold their value for this one cycle, and the bank samples them at the closing edge. At that edge, `oJ`/`oK` return to 0 and the FSM goes to CHECK.
- CHECK: `oReady`=0.
  - Compare `iQ` to the latched target and `iQ` to `~iQn`.
  - At the closing edge: `oDone`←1, `oErr`←(any mismatch), FSM→IDLE.
- The cycle after CHECK: `oDone`=1 for exactly that cycle and `oReady`=1. A new request may be accepted in this same cycle.
- `iValid` outside IDLE is ignored. The request is not queued, and the source must hold it until accepted.
- A target equal to the current Q still runs the full sequence with J=K=0.

## Timing
- Reset (async, immediate): state=IDLE, `oReady`=1, `oJ`=0, `oK`=0, `oDone`=0, `oErr`=0, latched target=0.
- Accept edge at end of cycle t. DRIVE is cycle t+1, and `oJ`/`oK` are valid only in t+1. The bank updates at the end of t+1. CHECK is cycle t+2. `oDone`/`oErr` are high in cycle t+3.
- Latency is 3 cycles from accept to `oDone`. Maximum throughput is one request per 3 cycles.
- Reset during DRIVE or CHECK aborts the request: no `oDone` is issued, and the bank is reset by the same `rst_n`.
- Excitation uses `iQ` sampled at the accept edge. Q is stable between accept and the DRIVE edge because `oJ`=`oK`=0 in IDLE.

## Structure
- Package `jk_pkg`: state typedef (IDLE/DRIVE/CHECK), excitation encoding constants.
- Sub-module `jk_excite`: combinational, N-wide. Inputs q, t, and TOGGLE_MODE; outputs j and k. It is instantiated once.
- The bench instantiates N JK flip-flops as the bank, with Q fed back to `iQ`/`iQn`.

## Test plan
- Reset: assert `rst_n`=0 mid-stream → all outputs at reset values, `oReady`=1; after release, bank Q=0000 and Qn=1111.
- N=4, TOGGLE_MODE=0, Q=0000, target 1010 → in DRIVE `oJ`=1010, `oK`=0000; `oDone` at t+3 with `oErr`=0; Q=1010.
- From Q=1010, target 0110: TOGGLE_MODE=0 → `oJ`=0100, `oK`=1000; TOGGLE_MODE=1 → `oJ`=`oK`=1100; Q=0110 with `oErr`=0 in both modes.
- Target equal to Q (0110→0110) → `oJ`=`oK`=0000, `oDone` at t+3, `oErr`=0. Also check that `iValid` pulses during DRIVE/CHECK are ignored.
- Fault injection: force `iQ[0]` stuck at 0, target 0001 → `oDone`=1 with `oErr`=1. Separately, force `iQn`=`iQ` on one bit → `oErr`=1.
- Reset asserted in DRIVE → `oJ`/`oK` go to 0 immediately, no `oDone` follows, and `oReady`=1 after release. A back-to-back request accepted in the `oDone` cycle completes 3 cycles later.
